// File: rtl/l2_arb_pkg.sv
// Shared helpers and types for the L2 bank round-robin arbiter.
package l2_arb_pkg;

   localparam int unsigned PayloadAddrWidth = 32;
   localparam int unsigned PayloadDataWidth = 32;
   localparam int unsigned PayloadBeWidth   = PayloadDataWidth / 8;

   typedef struct packed {
      logic [PayloadAddrWidth-1:0] add;
      logic                        wen;
      logic [PayloadDataWidth-1:0] wdata;
      logic [PayloadBeWidth-1:0]   be;
   } payload_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/l2_rr_pick.sv
// Round-robin winner selection: rotate by the pointer, fixed-priority encode, un-rotate.
module l2_rr_pick #(
   parameter int unsigned NB_MASTERS = 4,
   parameter int unsigned ID_WIDTH   = 2
) (
   input  logic [NB_MASTERS-1:0] req,
   input  logic [ID_WIDTH-1:0]   rr_ptr,
   output logic [ID_WIDTH-1:0]   winner,
   output logic                  valid
);

   logic [NB_MASTERS-1:0] rot;
   logic [ID_WIDTH-1:0]   enc;

   always_comb begin
      rot = '0;
      enc = '0;
      for (int i = 0; i < NB_MASTERS; i++) begin
         rot[i] = req[ID_WIDTH'((i + int'(rr_ptr)) % NB_MASTERS)];
      end
      // Walk downward so the lowest rotated index wins.
      for (int i = NB_MASTERS - 1; i >= 0; i--) begin
         if (rot[i]) enc = ID_WIDTH'(i);
      end
      valid  = |rot;
      winner = valid ? ID_WIDTH'((int'(enc) + int'(rr_ptr)) % NB_MASTERS) : '0;
   end

endmodule

// File: rtl/l2_bank_rr_arbiter.sv
// Round-robin arbiter for one L2 SRAM bank with a fixed 1-cycle response latency.
module l2_bank_rr_arbiter
   import l2_arb_pkg::*;
#(
   parameter int unsigned NB_MASTERS = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH   = idx_width(NB_MASTERS)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [NB_MASTERS-1:0]                m_req_i,
   input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0] m_add_i,
   input  logic [NB_MASTERS-1:0]                m_wen_i,
   input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i,
   input  logic [NB_MASTERS-1:0][BE_WIDTH-1:0]   m_be_i,
   output logic [NB_MASTERS-1:0]                m_gnt_o,
   output logic [NB_MASTERS-1:0]                m_r_valid_o,
   output logic [DATA_WIDTH-1:0]                m_r_rdata_o,
   output logic                                 bank_req_o,
   output logic [ADDR_WIDTH-1:0]                bank_add_o,
   output logic                                 bank_wen_o,
   output logic [DATA_WIDTH-1:0]                bank_wdata_o,
   output logic [BE_WIDTH-1:0]                  bank_be_o,
   input  logic                                 bank_gnt_i,
   input  logic                                 bank_r_valid_i,
   input  logic [DATA_WIDTH-1:0]                bank_r_rdata_i,
   output logic                                 err_o
);

   logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_WIDTH-1:0] resp_id_q;
   logic [ID_WIDTH-1:0] winner;
   logic                win_valid;
   logic                hs;
   logic                resp_pending_q;
   logic                err_q;

   l2_rr_pick #(
      .NB_MASTERS(NB_MASTERS),
      .ID_WIDTH  (ID_WIDTH)
   ) u_pick (
      .req   (m_req_i),
      .rr_ptr(rr_ptr_q),
      .winner(winner),
      .valid (win_valid)
   );

   // With no requester the picker returns index 0, so the mux idles on master 0.
   assign bank_req_o   = win_valid;
   assign bank_add_o   = m_add_i[winner];
   assign bank_wen_o   = m_wen_i[winner];
   assign bank_wdata_o = m_wdata_i[winner];
   assign bank_be_o    = m_be_i[winner];

   assign hs       = bank_req_o & bank_gnt_i;
   assign rr_ptr_d = (winner == ID_WIDTH'(NB_MASTERS - 1)) ? '0 : winner + 1'b1;

   always_comb begin
      m_gnt_o = '0;
      if (hs) m_gnt_o[winner] = 1'b1;
   end

   always_comb begin
      m_r_valid_o = '0;
      if (bank_r_valid_i && resp_pending_q) m_r_valid_o[resp_id_q] = 1'b1;
   end

   assign m_r_rdata_o = bank_r_rdata_i;
   assign err_o       = err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q       <= '0;
         resp_pending_q <= 1'b0;
         resp_id_q      <= '0;
         err_q          <= 1'b0;
      end else begin
         resp_pending_q <= hs;
         if (hs) begin
            resp_id_q <= winner;
            rr_ptr_q  <= rr_ptr_d;
         end
         // Response without a pending request, or a pending request without a response.
         if (bank_r_valid_i != resp_pending_q) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// Randomised and directed bench for l2_bank_rr_arbiter against a behavioural model.
module tb_l2_bank_rr_arbiter;

   localparam int N = 4;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic [N-1:0]        m_req_i;
   logic [N-1:0][31:0]  m_add_i;
   logic [N-1:0]        m_wen_i;
   logic [N-1:0][31:0]  m_wdata_i;
   logic [N-1:0][3:0]   m_be_i;
   logic [N-1:0]        m_gnt_o;
   logic [N-1:0]        m_r_valid_o;
   logic [31:0]         m_r_rdata_o;
   logic                bank_req_o;
   logic [31:0]         bank_add_o;
   logic                bank_wen_o;
   logic [31:0]         bank_wdata_o;
   logic [3:0]          bank_be_o;
   logic                bank_gnt_i;
   logic                bank_r_valid_i;
   logic [31:0]         bank_r_rdata_i;
   logic                err_o;

   l2_bank_rr_arbiter dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .m_req_i       (m_req_i),
      .m_add_i       (m_add_i),
      .m_wen_i       (m_wen_i),
      .m_wdata_i     (m_wdata_i),
      .m_be_i        (m_be_i),
      .m_gnt_o       (m_gnt_o),
      .m_r_valid_o   (m_r_valid_o),
      .m_r_rdata_o   (m_r_rdata_o),
      .bank_req_o    (bank_req_o),
      .bank_add_o    (bank_add_o),
      .bank_wen_o    (bank_wen_o),
      .bank_wdata_o  (bank_wdata_o),
      .bank_be_o     (bank_be_o),
      .bank_gnt_i    (bank_gnt_i),
      .bank_r_valid_i(bank_r_valid_i),
      .bank_r_rdata_i(bank_r_rdata_i),
      .err_o         (err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model state.
   int ptr_m;
   bit pend_m;
   int id_m;
   bit err_m;

   logic [N-1:0] obs_gnt, obs_rv, exp_gnt;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // Called at posedge+1 with requests set; checks this cycle, then advances the model.
   task automatic cycle(input bit rv_ok, input logic [31:0] rdata);
      int w, ws;
      bit hs_m;
      bank_r_valid_i = rv_ok ? pend_m : !pend_m;
      bank_r_rdata_i = rdata;
      #1;
      w  = pick(m_req_i, ptr_m);
      ws = (w < 0) ? 0 : w;
      hs_m = (w >= 0) && bank_gnt_i;
      exp_gnt = hs_m ? (N'(1) << w) : '0;
      obs_gnt = m_gnt_o;
      obs_rv  = m_r_valid_o;
      check("bank_req", bank_req_o, w >= 0);
      check("bank_add", bank_add_o, m_add_i[ws]);
      check("bank_wen", bank_wen_o, m_wen_i[ws]);
      check("bank_wdata", bank_wdata_o, m_wdata_i[ws]);
      check("bank_be", bank_be_o, m_be_i[ws]);
      check("gnt", m_gnt_o, exp_gnt);
      check("r_valid", m_r_valid_o, (pend_m && bank_r_valid_i) ? (N'(1) << id_m) : N'(0));
      check("r_rdata", m_r_rdata_o, rdata);
      check("err", err_o, err_m);
      @(posedge clk_i);
      #1;
      if (bank_r_valid_i != pend_m) err_m = 1'b1;
      pend_m = hs_m;
      if (hs_m) begin
         id_m  = w;
         ptr_m = (w + 1) % N;
      end
   endtask

   task automatic apply_reset();
      #2;
      rst_i = 1'b1;
      #1;
      check("rst_async_err", err_o, 1'b0);
      check("rst_async_rv", m_r_valid_o, '0);
      m_req_i        = '0;
      bank_gnt_i     = 1'b0;
      bank_r_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      check("rst_gnt", m_gnt_o, '0);
      check("rst_bank_req", bank_req_o, 1'b0);
      check("rst_err", err_o, 1'b0);
      rst_i  = 1'b0;
      ptr_m  = 0;
      pend_m = 1'b0;
      id_m   = 0;
      err_m  = 1'b0;
   endtask

   initial begin
      rst_i          = 1'b1;
      m_req_i        = '0;
      m_add_i        = '0;
      m_wen_i        = '1;
      m_wdata_i      = '0;
      m_be_i         = '0;
      bank_gnt_i     = 1'b0;
      bank_r_valid_i = 1'b0;
      bank_r_rdata_i = '0;
      ptr_m = 0; pend_m = 0; id_m = 0; err_m = 0;
      repeat (2) @(posedge clk_i);
      #1;
      check("reset_gnt", m_gnt_o, '0);
      check("reset_rv", m_r_valid_o, '0);
      check("reset_req", bank_req_o, 1'b0);
      check("reset_err", err_o, 1'b0);
      rst_i = 1'b0;
      repeat (2) cycle(1'b1, $urandom);

      // Round robin with all masters requesting.
      for (int i = 0; i < N; i++) m_add_i[i] = 32'h1000_0000 + 32'(i * 4);
      m_req_i    = '1;
      bank_gnt_i = 1'b1;
      for (int n = 0; n < 8; n++) begin
         cycle(1'b1, 32'hA5A5_0000 + 32'(n));
         check("rr_order", obs_gnt, N'(1) << (n % N));
         if (n > 0) check("rr_resp", obs_rv, N'(1) << ((n - 1) % N));
      end
      m_req_i = '0;
      cycle(1'b1, 32'hA5A5_0008);
      check("rr_last_resp", obs_rv, 4'b1000);

      // Single requester after advancing the pointer to 3.
      m_req_i = 4'b0100;
      cycle(1'b1, $urandom);
      cycle(1'b1, $urandom);
      check("single_gnt", obs_gnt, 4'b0100);
      m_req_i = 4'b1111;
      cycle(1'b1, $urandom);
      check("ptr_after_single", obs_gnt, 4'b1000);
      m_req_i = '0;
      cycle(1'b1, $urandom);

      // Write from master 1 stalled by the bank for two cycles.
      m_req_i      = 4'b0010;
      m_add_i[1]   = 32'h1C01_0004;
      m_wen_i[1]   = 1'b0;
      m_wdata_i[1] = 32'hDEAD_BEEF;
      m_be_i[1]    = 4'b0011;
      bank_gnt_i   = 1'b0;
      cycle(1'b1, $urandom);
      check("wr_stall1", obs_gnt, '0);
      check("wr_add", bank_add_o, 32'h1C01_0004);
      cycle(1'b1, $urandom);
      check("wr_stall2", obs_gnt, '0);
      check("wr_wdata", bank_wdata_o, 32'hDEAD_BEEF);
      bank_gnt_i = 1'b1;
      cycle(1'b1, $urandom);
      check("wr_gnt", obs_gnt, 4'b0010);
      m_req_i = '0;
      cycle(1'b1, $urandom);
      check("wr_rvalid", obs_rv, 4'b0010);

      // Random traffic honouring hold-until-granted.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!m_req_i[i] || exp_gnt[i]) begin
               m_req_i[i]   = ($urandom_range(0, 2) != 0);
               m_add_i[i]   = $urandom;
               m_wen_i[i]   = $urandom_range(0, 1);
               m_wdata_i[i] = $urandom;
               m_be_i[i]    = 4'($urandom);
            end
         end
         bank_gnt_i = ($urandom_range(0, 3) != 0);
         cycle(1'b1, $urandom);
      end
      m_req_i = '0;
      cycle(1'b1, $urandom);

      // Reset the cycle after a handshake.
      m_req_i    = 4'b0001;
      bank_gnt_i = 1'b1;
      cycle(1'b1, $urandom);
      m_req_i        = '0;
      bank_r_valid_i = 1'b1;
      #1;
      check("pre_rst_rv", m_r_valid_o, 4'b0001);
      apply_reset();
      m_req_i    = 4'b1010;
      bank_gnt_i = 1'b1;
      cycle(1'b1, $urandom);
      check("post_rst_lowest", obs_gnt, 4'b0010);
      m_req_i = '0;
      cycle(1'b1, $urandom);

      // Spurious response.
      cycle(1'b0, 32'h1234_5678);
      check("spurious_rv", obs_rv, '0);
      check("spurious_err", err_o, 1'b1);
      cycle(1'b1, $urandom);
      cycle(1'b1, $urandom);
      check("err_sticky", err_o, 1'b1);

      // Missing response.
      apply_reset();
      m_req_i    = 4'b0001;
      bank_gnt_i = 1'b1;
      cycle(1'b1, $urandom);
      m_req_i = '0;
      cycle(1'b0, $urandom);
      check("missing_rv", obs_rv, '0);
      check("missing_err", err_o, 1'b1);
      cycle(1'b1, $urandom);

      apply_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
